// File: rtl/mcu_sequencer.sv
// -----------------------------------------------------------------------------
// mcu_sequencer
// Control FSM for the MCU mux array and its N_CONV+2 line-memory banks.
// A frame is processed in three phases:
//   LOAD : host words are written bank by bank, row 0..H-1 inside each bank.
//   CONV : all banks are read row 0..H-1. Convolver results are written back
//          in place into the lower N_CONV banks at row r-2.
//   DONE : one-cycle o_done pulse, then return to IDLE.
//
// Optional feature (macro MCU_READBACK_EN):
//   Adds an UNLOAD phase after CONV. It streams the results out of banks
//   0..N_CONV-1, rows 0..H-3, and adds the ports o_outValid and i_outReady.
//   With the feature enabled, o_done pulses at the end of UNLOAD.
//
// Ports:
//   i_clock, i_reset (async, active-low)     clock / reset
//   i_start, i_imgHeight                     frame start, rows per bank (>=3)
//   i_dataValid / o_dataReady                host write handshake
//   o_inputCtrl, o_memCtrl, o_convCtrl       MUX_ARRAY selects
//   o_wrEnable, o_wrAddr, o_rdAddr           bank write enables and addresses
//   o_convValid                              window row valid at convolvers
//   o_busy, o_done                           status
//   o_dbgState                               current FSM state (debug)
//
// Handshake: a host word is transferred in every cycle where i_dataValid and
// o_dataReady are both high. The sender holds the word until that happens.
// o_dataReady is high only in LOAD. In UNLOAD, o_outValid/i_outReady follow
// the same rule.
// -----------------------------------------------------------------------------
module mcu_sequencer #(
  parameter int N_CONV      = 2,
  parameter int BITS_IMAGEN = 8,
  parameter int BITS_ADDR   = 10,
  parameter int CONV_LAT    = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [BITS_ADDR-1:0]  i_imgHeight,
  input  logic                  i_dataValid,
  output logic                  o_dataReady,
  output logic                  o_inputCtrl,
  output logic                  o_memCtrl,
  output logic                  o_convCtrl,
  output logic [N_CONV+1:0]     o_wrEnable,
  output logic [BITS_ADDR-1:0]  o_wrAddr,
  output logic [BITS_ADDR-1:0]  o_rdAddr,
  output logic                  o_convValid,
  output logic                  o_busy,
  output logic                  o_done,
`ifdef MCU_READBACK_EN
  output logic                  o_outValid,
  input  logic                  i_outReady,
`endif
  output logic [2:0]            o_dbgState
);

  localparam int N_BANKS = N_CONV + 2;
  localparam int BANK_W  = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;

  if (CONV_LAT < 1 || BITS_IMAGEN < 1) begin : g_badParams
    $error("mcu_sequencer: CONV_LAT and BITS_IMAGEN must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CONV   = 3'd2,
`ifdef MCU_READBACK_EN
    UNLOAD = 3'd4,
`endif
    DONE   = 3'd3
  } state_t;

  state_t                state;
  logic [BITS_ADDR-1:0]  height;
  logic [BITS_ADDR-1:0]  rowCnt;     // LOAD row counter
  logic [BANK_W-1:0]     bankCnt;    // LOAD bank counter
  logic [BITS_ADDR-1:0]  rdAddr;
  logic                  reading;    // a bank read is issued this cycle
  logic                  convValid;
  logic [BITS_ADDR-1:0]  convRow;    // row index presented with convValid
  logic [CONV_LAT-1:0]   winPipe;    // complete windows in flight through the convolvers
  logic [BITS_ADDR-1:0]  wbAddr;
  logic                  done;
`ifdef MCU_READBACK_EN
  logic [BANK_W-1:0]     unlBank;
  logic                  outValid;
  logic                  unloaded;   // UNLOAD already done for this frame
`endif

  logic [BITS_ADDR-1:0]  hLast;
  logic [BITS_ADDR-1:0]  hLast3;
  logic                  winNow;
  logic                  wbActive;

  assign hLast    = height - BITS_ADDR'(1);
  assign hLast3   = height - BITS_ADDR'(3);
  // Rows 0 and 1 only fill the window. From row 2 on, each row ends a window.
  assign winNow   = convValid && (convRow >= BITS_ADDR'(2));
  assign wbActive = winPipe[CONV_LAT-1];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      height    <= '0;
      rowCnt    <= '0;
      bankCnt   <= '0;
      rdAddr    <= '0;
      reading   <= 1'b0;
      convValid <= 1'b0;
      convRow   <= '0;
      winPipe   <= '0;
      wbAddr    <= '0;
      done      <= 1'b0;
`ifdef MCU_READBACK_EN
      unlBank   <= '0;
      outValid  <= 1'b0;
      unloaded  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start && (i_imgHeight >= BITS_ADDR'(3))) begin
            height    <= i_imgHeight;
            rowCnt    <= '0;
            bankCnt   <= '0;
            rdAddr    <= '0;
            reading   <= 1'b0;
            convValid <= 1'b0;
            convRow   <= '0;
            winPipe   <= '0;
            wbAddr    <= '0;
`ifdef MCU_READBACK_EN
            unloaded  <= 1'b0;
`endif
            state     <= LOAD;
          end
        end

        LOAD: begin
          if (i_dataValid) begin
            if (rowCnt == hLast) begin
              rowCnt <= '0;
              if (bankCnt == BANK_W'(N_BANKS - 1)) begin
                state   <= CONV;
                rdAddr  <= '0;
                reading <= 1'b1;
              end else begin
                bankCnt <= bankCnt + BANK_W'(1);
              end
            end else begin
              rowCnt <= rowCnt + BITS_ADDR'(1);
            end
          end
        end

        CONV: begin
          // Bank read latency is one cycle: the data for rdAddr is at the
          // convolvers in the next cycle.
          convValid <= reading;
          convRow   <= rdAddr;
          if (reading) begin
            if (rdAddr == hLast) reading <= 1'b0;
            else                 rdAddr  <= rdAddr + BITS_ADDR'(1);
          end
          winPipe <= CONV_LAT'({winPipe, winNow});
          if (wbActive) begin
            wbAddr <= wbAddr + BITS_ADDR'(1);
            if (wbAddr == hLast3) begin
              state <= DONE;
`ifndef MCU_READBACK_EN
              done  <= 1'b1;
`endif
            end
          end
        end

`ifdef MCU_READBACK_EN
        UNLOAD: begin
          // One read per word. Data is valid one cycle after the read is
          // issued, and the next read starts only after the word is taken.
          if (!outValid) begin
            outValid <= 1'b1;
          end else if (i_outReady) begin
            outValid <= 1'b0;
            if (rdAddr == hLast3) begin
              rdAddr <= '0;
              if (unlBank == BANK_W'(N_CONV - 1)) begin
                state    <= DONE;
                done     <= 1'b1;
                unloaded <= 1'b1;
              end else begin
                unlBank <= unlBank + BANK_W'(1);
              end
            end else begin
              rdAddr <= rdAddr + BITS_ADDR'(1);
            end
          end
        end
`endif

        DONE: begin
`ifdef MCU_READBACK_EN
          if (!unloaded) begin
            state    <= UNLOAD;
            rdAddr   <= '0;
            unlBank  <= '0;
            outValid <= 1'b0;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state only. The exception is the LOAD
  // write enable, which qualifies the current-cycle host handshake.
  assign o_busy      = (state != IDLE);
  assign o_dataReady = (state == LOAD);
  assign o_convCtrl  = (state == CONV);
`ifdef MCU_READBACK_EN
  assign o_inputCtrl = (state == LOAD) || (state == UNLOAD);
  assign o_memCtrl   = ((state == CONV) && wbActive) || (state == UNLOAD);
  assign o_outValid  = (state == UNLOAD) && outValid;
`else
  assign o_inputCtrl = (state == LOAD);
  assign o_memCtrl   = (state == CONV) && wbActive;
`endif
  assign o_wrEnable  = ((state == LOAD) && i_dataValid) ? (N_BANKS'(1) << bankCnt) :
                       ((state == CONV) && wbActive)    ? {2'b00, {N_CONV{1'b1}}} :
                                                          '0;
  assign o_wrAddr    = (state == LOAD) ? rowCnt : wbAddr;
  assign o_rdAddr    = rdAddr;
  assign o_convValid = convValid;
  assign o_done      = done;
  assign o_dbgState  = state;

endmodule

// File: tb/tb_mcu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mcu_sequencer
// Self-checking bench for mcu_sequencer (N_CONV=2, BITS_ADDR=10, CONV_LAT=2).
// Driver tasks push the expected write/done events into exp_q. A negedge
// monitor pops one entry for every event the DUT presents and compares them.
// Direct checks cover the selects, read addresses and reset behaviour.
// -----------------------------------------------------------------------------
module tb_mcu_sequencer;

  localparam int N_CONV    = 2;
  localparam int BITS_ADDR = 10;
  localparam int CONV_LAT  = 2;

  // ---------------- clock / reset ----------------
  logic i_clock;
  logic i_reset;
  int   cyc = 0;

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;
  always @(posedge i_clock) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic                 i_start;
  logic [BITS_ADDR-1:0] i_imgHeight;
  logic                 i_dataValid;
  logic                 o_dataReady, o_inputCtrl, o_memCtrl, o_convCtrl;
  logic [N_CONV+1:0]    o_wrEnable;
  logic [BITS_ADDR-1:0] o_wrAddr, o_rdAddr;
  logic                 o_convValid, o_busy, o_done;
  logic [2:0]           o_dbgState;
`ifdef MCU_READBACK_EN
  logic                 o_outValid;
  logic                 i_outReady;
`endif

  mcu_sequencer #(
    .N_CONV(N_CONV), .BITS_IMAGEN(8), .BITS_ADDR(BITS_ADDR), .CONV_LAT(CONV_LAT)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
    .i_imgHeight(i_imgHeight), .i_dataValid(i_dataValid),
    .o_dataReady(o_dataReady), .o_inputCtrl(o_inputCtrl),
    .o_memCtrl(o_memCtrl), .o_convCtrl(o_convCtrl),
    .o_wrEnable(o_wrEnable), .o_wrAddr(o_wrAddr), .o_rdAddr(o_rdAddr),
    .o_convValid(o_convValid), .o_busy(o_busy), .o_done(o_done),
`ifdef MCU_READBACK_EN
    .o_outValid(o_outValid), .i_outReady(i_outReady),
`endif
    .o_dbgState(o_dbgState)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int nCompared   = 0;
  int nMismatched = 0;

  function automatic logic [31:0] pack_ev(input int stamp, input logic done,
                                          input logic mem, input logic [3:0] we,
                                          input logic [9:0] addr);
    logic [31:0] s;
    s = stamp;
    return {s[15:0], done, mem, we, addr};
  endfunction

  function automatic logic [31:0] all_outs();
`ifdef MCU_READBACK_EN
    return {o_outValid, o_dataReady, o_inputCtrl, o_memCtrl, o_convCtrl, o_wrEnable,
            o_wrAddr, o_rdAddr, o_convValid, o_busy, o_done};
`else
    return {1'b0, o_dataReady, o_inputCtrl, o_memCtrl, o_convCtrl, o_wrEnable,
            o_wrAddr, o_rdAddr, o_convValid, o_busy, o_done};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every write or done pulse is an event that must match exp_q.
  always @(negedge i_clock) begin
    logic [31:0] act, expv;
    if ((o_wrEnable != '0) || o_done) begin
      act = pack_ev(cyc, o_done, o_memCtrl, o_wrEnable, o_wrAddr & {10{|o_wrEnable}});
      nCompared++;
      if (exp_q.size() == 0) begin
        nMismatched++;
        $display("FAIL event @cycle %0d: got %h, none expected", cyc, act);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          nMismatched++;
          $display("FAIL event @cycle %0d: got %h, expected %h", cyc, act, expv);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Runs one frame of height h. gapMode 1 drives i_dataValid as 1,0,0,1.
  // resetAt >= 0 pulls reset in CONV cycle c+resetAt.
  task automatic run_frame(input int h, input int gapMode, input int resetAt);
    int acc, i, c;
    logic [3:0] we;
    i_imgHeight = 10'(h);
    i_start     = 1'b1;
    i_dataValid = 1'b0;
    tick();
    i_start = 1'b0;
    acc = 0;
    i   = 0;
    while (acc < 4 * h) begin
      i_dataValid = (gapMode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
      check("load_sel", {o_inputCtrl, o_convCtrl, o_dataReady}, 3'b101);
      if (i_dataValid) begin
        we = 4'b0001 << (acc / h);
        exp_q.push_back(pack_ev(cyc, 1'b0, 1'b0, we, 10'(acc % h)));
        acc++;
      end
      i++;
      tick();
    end
    // i_dataValid stays high through CONV and must be ignored there.
    c = cyc;
    check("conv_sel", {o_convCtrl, o_inputCtrl, o_dataReady}, 3'b100);
    if (resetAt < 0) begin
      for (int r = 2; r < h; r++)
        exp_q.push_back(pack_ev(c + r + 1 + CONV_LAT, 1'b0, 1'b1, 4'b0011, 10'(r - 2)));
      exp_q.push_back(pack_ev(c + h + CONV_LAT + 1, 1'b1, 1'b0, 4'b0000, 10'd0));
    end
    for (int t = 0; t <= h + CONV_LAT + 2; t++) begin
      if (t == resetAt) begin
        i_reset = 1'b0;
        #1;
        check("async_reset_outs", all_outs(), 32'd0);
        i_dataValid = 1'b0;
        tick();
        tick();
        i_reset = 1'b1;
        tick();
        return;
      end
      if (t < h)  check("rd_addr", o_rdAddr, t);
      if (t == h) check("rd_addr_hold", o_rdAddr, h - 1);
      if (t >= 1 && t <= h) check("conv_valid", o_convValid, 1);
      if (t == 1) i_start = 1'b1;
      if (t == 2) i_start = 1'b0;
      if (t == h + CONV_LAT + 1) check("busy_in_done", o_busy, 1);
      if (t == h + CONV_LAT + 2) begin
        check("idle_after_done", {o_busy, o_convCtrl}, 2'b00);
        i_dataValid = 1'b0;
      end else begin
        tick();
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_reset     = 1'b0;
    i_start     = 1'b0;
    i_imgHeight = '0;
    i_dataValid = 1'b0;
`ifdef MCU_READBACK_EN
    i_outReady  = 1'b1;
`endif
    // Reset held with random inputs: every output must stay 0.
    for (int k = 0; k < 5; k++) begin
      i_start     = 1'($urandom_range(0, 1));
      i_dataValid = 1'($urandom_range(0, 1));
      i_imgHeight = 10'($urandom_range(0, 1023));
      #2;
      check("reset_outs", all_outs(), 32'd0);
      tick();
    end
    i_start     = 1'b0;
    i_dataValid = 1'b0;
    i_imgHeight = '0;
    i_reset     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("idle_outs", all_outs(), 32'd0);
    end

    // Full frame, H=4, data always valid.
    run_frame(4, 0, -1);
    // Full frame, H=4, backpressure 1,0,0,1.
    run_frame(4, 1, -1);

    // Start with H=2 is ignored.
    i_imgHeight = 10'd2;
    i_start     = 1'b1;
    tick();
    i_start = 1'b0;
    check("h2_ignored_busy", o_busy, 0);
    tick();
    check("h2_ignored_busy2", o_busy, 0);

    // Reset in the middle of CONV, then a clean H=3 frame.
    run_frame(4, 0, 3);
    check("post_reset_busy", o_busy, 0);
    run_frame(3, 0, -1);

    for (int k = 0; k < 4; k++) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
